alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
- Drives the registered 32-bit ALU from the issuing side.
- Accepts a valid/ready operation request carrying a MIPS-style ALUOp/funct encoding. Decodes it into the 4-bit ALU_control code and drives src1/src2/ALU_control to the ALU.
- Waits out the ALU's registered latency, captures result/zero/cout/overflow, and returns them on a valid/ready response channel.
- Sits between the datapath control FSM and the ALU instance.

Parameters:
- ALU_LAT, 1, clock edges between stable ALU inputs and valid registered ALU outputs (1 to 7).
- TAG_W, 4, width of the request/response tag.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- req_valid  input  1  request present
- req_ready  output  1  request accepted when req_valid && req_ready
- req_aluop  input  2  00 add, 01 sub, 10 R-type (use funct), 11 illegal
- req_funct  input  6  R-type funct field
- req_a  input  32  operand A
- req_b  input  32  operand B
- req_tag  input  TAG_W  echoed on response
- alu_src1  output  32  to ALU src1
- alu_src2  output  32  to ALU src2
- alu_control  output  4  to ALU ALU_control
- alu_result  input  32  from ALU result
- alu_zero  input  1  from ALU zero
- alu_cout  input  1  from ALU cout
- alu_overflow  input  1  from ALU overflow
- rsp_valid  output  1  response present
- rsp_ready  input  1  response consumed when rsp_valid && rsp_ready
- rsp_result  output  32  captured result
- rsp_zero  output  1  captured zero
- rsp_cout  output  1  captured cout
- rsp_overflow  output  1  captured overflow
- rsp_illegal  output  1  request encoding was illegal
- rsp_tag  output  TAG_W  tag of the request
- ovf_count  output  16  saturating count of delivered responses with rsp_overflow=1

Behaviour:
- Reset: one clock, synchronous, active-high. rst sampled high at a rising edge forces IDLE.
  - All outputs 0 except req_ready=1 (IDLE).
  - ovf_count is cleared; the in-flight operation is dropped with no response.
  - Reset has priority over every other event.
- Decode (aluop 10 uses funct):
  - 100000 → 0010 (add)
  - 100010 → 0110 (sub)
  - 100100 → 0000 (and)
  - 100101 → 0001 (or)
  - 100111 → 1100 (nor)
  - 101010 → 0111 (slt)
  - Any other funct → illegal.
  - aluop 00 → 0010; aluop 01 → 0110; aluop 11 → illegal.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE:
    - req_ready=1.
    - On accept, register operands, decoded code and tag.
    - Legal request → ISSUE. Illegal request → RESP with rsp_result=0, all flags 0, rsp_illegal=1, and no ALU operation.
  - ISSUE:
    - One cycle. alu_src1/alu_src2/alu_control present the registered values.
    - Load the wait counter with ALU_LAT → WAIT.
  - WAIT:
    - Decrement the counter each cycle; ALU inputs are held stable.
    - In the cycle the counter equals 1, capture alu_result/zero/cout/overflow into the rsp registers, with rsp_illegal=0 → RESP.
  - RESP:
    - rsp_valid=1; all rsp_* are held stable until rsp_ready.
    - On handshake → IDLE. ovf_count increments if rsp_overflow=1 and is saturating at 0xFFFF.
- Latency and throughput:
  - Legal request: accept edge → rsp_valid high for the first time after ALU_LAT+2 edges (3 for the default).
  - Illegal request: rsp_valid high after 1 edge.
  - One operation in flight at a time; req_ready=0 in ISSUE/WAIT/RESP. A new request is accepted no earlier than the cycle after the response handshake.
- ALU drive outside ISSUE/WAIT: alu_src1/alu_src2/alu_control keep their last values (0 after reset). ALU outputs are ignored outside the capture cycle.
- Flags are passed through unmodified. Suppression of cout/overflow for slt is the ALU's responsibility.
- rsp_valid never drops without a handshake, except on reset.

Test Plan:
- Add, no backpressure: aluop 00, a=7, b=5, rsp_ready=1 → alu_control=0010. rsp_valid 3 cycles after accept, result 0x0000000C, zero 0, illegal 0, tag echoed.
- Sub to zero: aluop 01, a=b=0x12345678 → alu_control=0110, result 0, rsp_zero=1.
- Slt and overflow:
  - aluop 10, funct 101010, a=3, b=5 → alu_control=0111, result 1, overflow 0.
  - Then aluop 00, a=0x7FFFFFFF, b=1 → result 0x80000000, rsp_overflow=1, ovf_count=1.
- Backpressure: hold rsp_ready=0 for 4 cycles after rsp_valid rises, with req_valid=1 and a new request → rsp_* stable, req_ready=0 throughout. Second request accepted the cycle after the handshake.
- Illegal encodings: aluop 10, funct 000000 → rsp_valid after 1 edge, rsp_illegal=1, result 0, alu_control unchanged. aluop 11 → same.
- Reset mid-WAIT: assert rst for 1 cycle during WAIT → next cycle IDLE, req_ready=1, rsp_valid=0, ovf_count=0. No response is ever produced for the dropped request.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// Issue-side controller for the registered 32-bit ALU: decodes ALUOp/funct,
// holds operands stable for the ALU latency and returns the captured result.
module alu_issue_ctrl #(
  parameter int ALU_LAT = 1,
  parameter int TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_aluop,
  input  logic [5:0]       req_funct,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic [31:0]      alu_src1,
  output logic [31:0]      alu_src2,
  output logic [3:0]       alu_control,
  input  logic [31:0]      alu_result,
  input  logic             alu_zero,
  input  logic             alu_cout,
  input  logic             alu_overflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic             rsp_zero,
  output logic             rsp_cout,
  output logic             rsp_overflow,
  output logic             rsp_illegal,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [15:0]      ovf_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [2:0] LAT_INIT = 3'(ALU_LAT);

  state_t             r_state;
  state_t             w_next;
  logic [2:0]         r_cnt;
  logic [31:0]        r_src1;
  logic [31:0]        r_src2;
  logic [3:0]         r_ctrl;
  logic [31:0]        r_rspResult;
  logic               r_rspZero;
  logic               r_rspCout;
  logic               r_rspOverflow;
  logic               r_rspIllegal;
  logic [TAG_W-1:0]   r_rspTag;
  logic [15:0]        r_ovfCount;
  logic               w_legal;
  logic [3:0]         w_code;
  logic               w_accept;
  logic               w_rspHs;

  always_comb begin
    w_legal = 1'b1;
    w_code  = 4'b0000;
    case (req_aluop)
      2'b00: w_code = 4'b0010;
      2'b01: w_code = 4'b0110;
      2'b10: begin
        case (req_funct)
          6'b100000: w_code = 4'b0010;
          6'b100010: w_code = 4'b0110;
          6'b100100: w_code = 4'b0000;
          6'b100101: w_code = 4'b0001;
          6'b100111: w_code = 4'b1100;
          6'b101010: w_code = 4'b0111;
          default:   w_legal = 1'b0;
        endcase
      end
      default: w_legal = 1'b0;
    endcase
  end

  assign w_accept = req_valid && (r_state == IDLE);
  assign w_rspHs  = rsp_ready && (r_state == RESP);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = w_legal ? ISSUE : RESP;
      end
      ISSUE: w_next = WAIT;
      WAIT: begin
        if (r_cnt == 3'd1) w_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Illegal requests never touch the ALU drive registers, so the ALU keeps
  // seeing the last legal operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt         <= '0;
      r_src1        <= '0;
      r_src2        <= '0;
      r_ctrl        <= '0;
      r_rspResult   <= '0;
      r_rspZero     <= 1'b0;
      r_rspCout     <= 1'b0;
      r_rspOverflow <= 1'b0;
      r_rspIllegal  <= 1'b0;
      r_rspTag      <= '0;
      r_ovfCount    <= '0;
    end else begin
      if (w_accept) begin
        r_rspTag <= req_tag;
        if (w_legal) begin
          r_src1 <= req_a;
          r_src2 <= req_b;
          r_ctrl <= w_code;
        end else begin
          r_rspResult   <= '0;
          r_rspZero     <= 1'b0;
          r_rspCout     <= 1'b0;
          r_rspOverflow <= 1'b0;
          r_rspIllegal  <= 1'b1;
        end
      end
      if (r_state == ISSUE) r_cnt <= LAT_INIT;
      if (r_state == WAIT) begin
        r_cnt <= r_cnt - 3'd1;
        if (r_cnt == 3'd1) begin
          r_rspResult   <= alu_result;
          r_rspZero     <= alu_zero;
          r_rspCout     <= alu_cout;
          r_rspOverflow <= alu_overflow;
          r_rspIllegal  <= 1'b0;
        end
      end
      if (w_rspHs && r_rspOverflow && (r_ovfCount != 16'hFFFF))
        r_ovfCount <= r_ovfCount + 16'd1;
    end
  end

  assign alu_src1     = r_src1;
  assign alu_src2     = r_src2;
  assign alu_control  = r_ctrl;
  assign rsp_result   = r_rspResult;
  assign rsp_zero     = r_rspZero;
  assign rsp_cout     = r_rspCout;
  assign rsp_overflow = r_rspOverflow;
  assign rsp_illegal  = r_rspIllegal;
  assign rsp_tag      = r_rspTag;
  assign ovf_count    = r_ovfCount;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: a behavioural registered ALU plus a
// request-level reference model driving directed and randomized transactions.
module tb_alu_issue_ctrl;

  localparam int ALU_LAT = 1;
  localparam int TAG_W   = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_aluop;
  logic [5:0]       req_funct;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic [TAG_W-1:0] req_tag;
  logic [31:0]      alu_src1;
  logic [31:0]      alu_src2;
  logic [3:0]       alu_control;
  logic [31:0]      alu_result = '0;
  logic             alu_zero = 1'b0;
  logic             alu_cout = 1'b0;
  logic             alu_overflow = 1'b0;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_result;
  logic             rsp_zero;
  logic             rsp_cout;
  logic             rsp_overflow;
  logic             rsp_illegal;
  logic [TAG_W-1:0] rsp_tag;
  logic [15:0]      ovf_count;

  int passCount = 0;
  int checkCount = 0;
  logic [3:0]  lastCtrl = 4'b0000;
  logic [15:0] ovfModel = 16'd0;

  alu_issue_ctrl #(.ALU_LAT(ALU_LAT), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_aluop(req_aluop), .req_funct(req_funct),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .alu_cout(alu_cout), .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .rsp_cout(rsp_cout), .rsp_overflow(rsp_overflow),
    .rsp_illegal(rsp_illegal), .rsp_tag(rsp_tag),
    .ovf_count(ovf_count)
  );

  always #5 clk = ~clk;

  // Returns {overflow, cout, result} for one ALU operation.
  function automatic logic [33:0] aluCompute(input logic [3:0] ctrl,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    logic [32:0] sum;
    logic        ovf;
    case (ctrl)
      4'b0010: begin
        sum = {1'b0, a} + {1'b0, b};
        ovf = (a[31] == b[31]) && (sum[31] != a[31]);
        return {ovf, sum[32], sum[31:0]};
      end
      4'b0110: begin
        sum = {1'b0, a} + {1'b0, ~b} + 33'd1;
        ovf = (a[31] != b[31]) && (sum[31] != a[31]);
        return {ovf, sum[32], sum[31:0]};
      end
      4'b0000: return {2'b00, a & b};
      4'b0001: return {2'b00, a | b};
      4'b1100: return {2'b00, ~(a | b)};
      4'b0111: return {2'b00, 31'd0, ($signed(a) < $signed(b))};
      default: return 34'd0;
    endcase
  endfunction

  // Stand-in for the registered ALU (one-edge latency).
  always @(posedge clk) begin
    logic [33:0] r;
    r = aluCompute(alu_control, alu_src1, alu_src2);
    alu_result   <= r[31:0];
    alu_zero     <= (r[31:0] == 32'd0);
    alu_cout     <= r[32];
    alu_overflow <= r[33];
  end

  function automatic void decodeRef(input logic [1:0] aluop, input logic [5:0] funct,
                                    output logic legal, output logic [3:0] code);
    legal = 1'b1;
    code  = 4'b0000;
    if (aluop == 2'b00) code = 4'b0010;
    else if (aluop == 2'b01) code = 4'b0110;
    else if (aluop == 2'b11) legal = 1'b0;
    else if (funct == 6'h20) code = 4'b0010;
    else if (funct == 6'h22) code = 4'b0110;
    else if (funct == 6'h24) code = 4'b0000;
    else if (funct == 6'h25) code = 4'b0001;
    else if (funct == 6'h27) code = 4'b1100;
    else if (funct == 6'h2A) code = 4'b0111;
    else legal = 1'b0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", name, observed, expected);
  endtask

  // Runs one complete transaction; called right after a falling edge.
  task automatic applyStimulus(input logic [1:0] aluop, input logic [5:0] funct,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [TAG_W-1:0] tag, input int stall);
    logic        legal;
    logic [3:0]  code;
    logic [33:0] r;
    logic [31:0] expResult;
    logic        expOvf, expCout;
    int          edges;
    int          expLat;
    decodeRef(aluop, funct, legal, code);
    r         = legal ? aluCompute(code, a, b) : 34'd0;
    expResult = r[31:0];
    expCout   = r[32];
    expOvf    = r[33];
    expLat    = legal ? ALU_LAT + 2 : 1;

    req_valid = 1'b1;
    req_aluop = aluop;
    req_funct = funct;
    req_a     = a;
    req_b     = b;
    req_tag   = tag;
    checkOutput("reqReadyIdle", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    edges = 1;
    if (!legal) checkOutput("ctrlUnchanged", 32'(alu_control), 32'(lastCtrl));
    else begin
      checkOutput("issueSrc1", alu_src1, a);
      checkOutput("issueSrc2", alu_src2, b);
    end
    while (!rsp_valid && edges < 30) begin
      checkOutput("busyReqReady", 32'(req_ready), 32'd0);
      if (legal) checkOutput("aluControl", 32'(alu_control), 32'(code));
      @(posedge clk);
      @(negedge clk);
      edges++;
    end
    checkOutput("latency", 32'(edges), 32'(expLat));
    checkOutput("rspResult", rsp_result, expResult);
    checkOutput("rspZero", 32'(rsp_zero), 32'(legal && expResult == 32'd0));
    checkOutput("rspCout", 32'(rsp_cout), 32'(expCout));
    checkOutput("rspOverflow", 32'(rsp_overflow), 32'(expOvf));
    checkOutput("rspIllegal", 32'(rsp_illegal), 32'(!legal));
    checkOutput("rspTag", 32'(rsp_tag), 32'(tag));

    for (int i = 0; i < stall; i++) begin
      req_valid = 1'b1;
      req_aluop = 2'($urandom_range(0, 3));
      req_funct = 6'($urandom);
      req_a     = $urandom;
      req_b     = $urandom;
      req_tag   = TAG_W'($urandom);
      @(posedge clk);
      @(negedge clk);
      checkOutput("stallValid", 32'(rsp_valid), 32'd1);
      checkOutput("stallReqReady", 32'(req_ready), 32'd0);
      checkOutput("stallResult", rsp_result, expResult);
      checkOutput("stallTag", 32'(rsp_tag), 32'(tag));
    end

    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    if (legal) lastCtrl = code;
    if (legal && expOvf && ovfModel != 16'hFFFF) ovfModel = ovfModel + 16'd1;
    checkOutput("postHsValid", 32'(rsp_valid), 32'd0);
    checkOutput("postHsReady", 32'(req_ready), 32'd1);
    checkOutput("ovfCount", 32'(ovf_count), 32'(ovfModel));
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 5))
      0: return 32'h7FFFFFFF;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'd0;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [5:0] pickFunct();
    case ($urandom_range(0, 7))
      0: return 6'h20;
      1: return 6'h22;
      2: return 6'h24;
      3: return 6'h25;
      4: return 6'h27;
      5: return 6'h2A;
      default: return 6'($urandom);
    endcase
  endfunction

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_aluop = 2'b00;
    req_funct = 6'd0;
    req_a     = '0;
    req_b     = '0;
    req_tag   = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("resetReqReady", 32'(req_ready), 32'd1);
    checkOutput("resetRspValid", 32'(rsp_valid), 32'd0);
    checkOutput("resetOvfCount", 32'(ovf_count), 32'd0);
    checkOutput("resetAluControl", 32'(alu_control), 32'd0);
    checkOutput("resetRspResult", rsp_result, 32'd0);

    applyStimulus(2'b00, 6'd0, 32'd7, 32'd5, 4'h3, 0);
    applyStimulus(2'b01, 6'd0, 32'h12345678, 32'h12345678, 4'h5, 0);
    applyStimulus(2'b10, 6'h2A, 32'd3, 32'd5, 4'h6, 0);
    applyStimulus(2'b00, 6'd0, 32'h7FFFFFFF, 32'd1, 4'h7, 4);
    applyStimulus(2'b10, 6'h22, 32'h80000000, 32'd1, 4'h8, 0);
    applyStimulus(2'b10, 6'd0, 32'd9, 32'd9, 4'h9, 1);
    applyStimulus(2'b11, 6'h20, 32'd1, 32'd2, 4'hA, 0);

    for (int n = 0; n < 40; n++) begin
      logic [1:0] op;
      op = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      applyStimulus(op, pickFunct(), pickOperand(), pickOperand(),
                    TAG_W'($urandom), int'($urandom_range(0, 3)));
    end

    // Reset arriving while the operation is waiting on the ALU.
    applyStimulus(2'b00, 6'd0, 32'h7FFFFFFF, 32'h7FFFFFFF, 4'hB, 0);
    req_valid = 1'b1;
    req_aluop = 2'b00;
    req_a     = 32'd100;
    req_b     = 32'd200;
    req_tag   = 4'hC;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    lastCtrl = 4'b0000;
    ovfModel = 16'd0;
    checkOutput("midResetReqReady", 32'(req_ready), 32'd1);
    checkOutput("midResetRspValid", 32'(rsp_valid), 32'd0);
    checkOutput("midResetOvfCount", 32'(ovf_count), 32'd0);
    checkOutput("midResetAluControl", 32'(alu_control), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("droppedNoRsp", 32'(rsp_valid), 32'd0);
    end
    applyStimulus(2'b10, 6'h25, 32'hF0F0_0000, 32'h0000_0F0F, 4'hD, 2);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
